ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter; the send direction for the existing PS/2 keyboard receive path.
//  Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
//  Drives the open-drain clock and data lines and checks the device ACK.
//  Sits beside the keyboard receiver in the apple1 system on clk25.
//  Holds rx_inhibit high while sending so the receiver ignores the bus.
// PARAMETERS
//  INHIBIT_CYCLES  3000    clk25 cycles ps2 clock is held low before start (120 us)
//  TIMEOUT_CYCLES  375000  max cycles from clock release to ACK (15 ms)
//  FILTER_LEN      8       consecutive equal samples needed to accept a PS/2 line level
// PORTS
//  clk25        in   1  system clock, 25 MHz
//  rst          in   1  synchronous reset, active-high
//  tx_data      in   8  byte to send
//  tx_valid     in   1  request; accepted when tx_valid && tx_ready
//  tx_ready     out  1  high only in IDLE
//  ps2_clk_in   in   1  PS/2 clock pin level, asynchronous
//  ps2_data_in  in   1  PS/2 data pin level, asynchronous
//  ps2_clk_oe   out  1  1 = pull the clock pin low; 0 = release (high-Z)
//  ps2_data_oe  out  1  1 = pull the data pin low; 0 = release
//  rx_inhibit   out  1  high from accept until DONE/ERROR; the receiver discards frames while high
//  done         out  1  1-cycle pulse: byte sent and ACK seen
//  error        out  1  1-cycle pulse: NACK or timeout
// BEHAVIOUR
//  Reset values:
//   - tx_ready=1; all other outputs 0; FSM in IDLE; counters cleared.
//   - Applying rst mid-frame releases both lines on the next clk25 edge. No done or error pulse is produced.
//  Input conditioning:
//   - Each input goes through a 2-FF synchroniser, then the FILTER_LEN filter.
//   - fall = 1-cycle strobe when the filtered clock goes 1->0.
//  Accept: the shift register loads {parity, tx_data}. parity = ~^tx_data (odd parity). tx_ready drops the next cycle.
//  FSM:
//   - IDLE: on accept go to INHIBIT.
//   - INHIBIT: clk_oe=1 for INHIBIT_CYCLES. In the last cycle set data_oe=1 (start bit). Then go to REQ.
//   - REQ: clk_oe=0, data_oe stays 1. Start the timeout counter. Go to BITS.
//   - BITS: on each fall, set data_oe = ~shift[0] and shift right.
//     - Falls 1-8 send data bits LSB first; fall 9 sends parity.
//     - On fall 10, data_oe=0 (stop bit released). Go to ACK.
//   - ACK: on the next fall, sample filtered data. 0 = ACK, go to WAIT_IDLE; 1 = NACK, go to ERROR.
//   - WAIT_IDLE: wait until both filtered lines are 1, then go to DONE.
//   - DONE: pulse done, drop rx_inhibit, raise tx_ready. Go to IDLE.
//   - ERROR: both oe=0, pulse error, drop rx_inhibit. Go to IDLE.
//  Timeout: if the counter reaches TIMEOUT_CYCLES in REQ, BITS, ACK or WAIT_IDLE, go to ERROR at once. The counter is 19 bits and saturates.
//  Requests while busy: tx_valid is ignored; there is no queue. tx_data is captured only at accept.
//  Bus activity: a fall while in IDLE or INHIBIT is ignored. The host owns the bus after accept.
//  Timing: outputs are registered. data_oe changes 1 cycle after the fall strobe, about FILTER_LEN+3 cycles after the pin edge. This is well inside the device's 5 us setup window.
// CONFIGURATION
//  PS2_TX_RETRY_EN:
//   - Defined: a NACK or timeout restarts at INHIBIT with the same byte, up to 2 retries.
//     error pulses only after the 3rd failure. rx_inhibit stays high across retries.
//   - Undefined: the first failure goes straight to ERROR. The retry counter is not built.
// STRUCTURE
//  ps2_pkg:
//   - FSM state localparams: IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE, DONE, ERROR.
//   - PS2_FRAME_FALLS=10, MAX_RETRY=2.
//   - Common PS/2 command codes: 0xED, 0xF4, 0xFF.
//  Sub-module ps2_line_filter: synchroniser + glitch filter + fall strobe.
//   - Two instances here, one per line. The keyboard receiver reuses it.
// TESTING
//  1. Send 0xED. Device model ACKs. Expect:
//     - clk_oe low for 3000 cycles, then start bit 0;
//     - bits 1,0,1,1,0,1,1,1, then parity 1, then stop;
//     - done 1 pulse; error stays 0.
//  2. Send 0xF4. Expect parity 0. Device holds data high at the ACK fall. Expect error pulse and tx_ready=1.
//  3. Device never clocks. Expect error exactly TIMEOUT_CYCLES after REQ, and both oe = 0.
//  4. Assert tx_valid with 0x00 while busy sending 0xFF. Expect it ignored: only 0xFF appears on the bus and a single done pulse.
//  5. Assert rst after the 4th fall. Expect both oe = 0 next cycle, tx_ready=1, and no done/error.
//  6. With PS2_TX_RETRY_EN defined, the device NACKs twice, then ACKs. Expect 3 frames of 0xED, one done, and rx_inhibit high throughout.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame constants,
// common keyboard command codes and the odd-parity helper.
`timescale 1ns/1ps
package ps2_pkg;

  // Host transmitter FSM states
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAIT_IDLE,
    DONE,
    ERROR
  } ps2_tx_state_t;

  // Falls that carry a frame: 8 data bits, parity, stop release
  localparam int PS2_FRAME_FALLS = 10;
  // Extra attempts after a failed frame when retries are built
  localparam int MAX_RETRY       = 2;

  // Common host-to-keyboard commands
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // PS/2 uses odd parity: the 9 transmitted bits hold an odd count of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchroniser, level filter that needs
// FILTER_LEN consecutive equal samples before accepting a new level,
// and a one-cycle strobe on each accepted 1->0 transition.
// The idle level of an open-drain PS/2 line is high, so reset reports 1.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Synchronise the pin, then accept a new level only after it has differed
  // from the current one for FILTER_LEN samples in a row; any return to the
  // current level restarts the count, which swallows short glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
      r_fall  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(FILTER_LEN - 1)) begin
          r_level <= r_sync2;
          r_fall  <= ~r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard
// by inhibiting the clock, issuing request-to-send, shifting data/parity out
// on device clock falls and checking the device ACK. rx_inhibit tells the
// neighbouring receiver to ignore the bus while a send is in flight.
// Optional feature macro: PS2_TX_RETRY_EN -- when defined, a NACK or timeout
// restarts the frame with the same byte up to MAX_RETRY more times before
// error is reported.
`timescale 1ns/1ps
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  ps2_tx_state_t  r_state;
  logic [8:0]     r_shift;
  logic [INH_W-1:0] r_cnt;
  logic [18:0]    r_to;
  logic [3:0]     r_nfall;
  logic           r_tx_ready;
  logic           r_clk_oe;
  logic           r_data_oe;
  logic           r_rx_inhibit;
  logic           r_done;
  logic           r_error;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]     r_retry;
  logic [8:0]     r_byte;
`endif

  logic        w_clk_level;
  logic        w_clk_fall;
  logic        w_data_level;
  logic        w_data_fall_unused;
  logic [18:0] w_to_next;
  logic        w_timeout;
  logic        w_nack;
  logic        w_fail;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk25),
    .rst     (rst),
    .i_line  (ps2_clk_in),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk25),
    .rst     (rst),
    .i_line  (ps2_data_in),
    .o_level (w_data_level),
    .o_fall  (w_data_fall_unused)
  );

  // Saturating timeout count; a stuck device can never wrap it back to zero
  assign w_to_next = (r_to == '1) ? r_to : r_to + 19'd1;

  // Failure detection: timeout while waiting on the device, or data high at the ACK fall
  always_comb begin
    w_timeout = 1'b0;
    w_nack    = 1'b0;
    if (r_state inside {BITS, ACK, WAIT_IDLE})
      w_timeout = (w_to_next >= 19'(TIMEOUT_CYCLES));
    if (r_state == ACK && w_clk_fall && w_data_level)
      w_nack = 1'b1;
  end

  assign w_fail = w_timeout | w_nack;

  // Transmit FSM with registered line enables and handshake outputs
  always_ff @(posedge clk25) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_to         <= '0;
      r_nfall      <= '0;
      r_tx_ready   <= 1'b1;
      r_clk_oe     <= 1'b0;
      r_data_oe    <= 1'b0;
      r_rx_inhibit <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      r_retry      <= '0;
      r_byte       <= '0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (w_fail) begin
`ifdef PS2_TX_RETRY_EN
        // Restart the whole frame with the saved byte; rx_inhibit stays high
        if (r_retry != 2'(MAX_RETRY)) begin
          r_retry   <= r_retry + 2'd1;
          r_state   <= INHIBIT;
          r_clk_oe  <= 1'b1;
          r_data_oe <= 1'b0;
          r_cnt     <= '0;
          r_shift   <= r_byte;
        end else begin
          r_state <= ERROR;
        end
`else
        r_state <= ERROR;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (tx_valid) begin
              r_shift      <= {odd_parity(tx_data), tx_data};
              r_state      <= INHIBIT;
              r_tx_ready   <= 1'b0;
              r_rx_inhibit <= 1'b1;
              r_clk_oe     <= 1'b1;
              r_data_oe    <= 1'b0;
              r_cnt        <= '0;
`ifdef PS2_TX_RETRY_EN
              r_byte       <= {odd_parity(tx_data), tx_data};
              r_retry      <= '0;
`endif
            end
          end
          INHIBIT: begin
            // clk_oe was raised at accept; the start bit goes out in its last cycle
            if (r_cnt == INH_W'(INHIBIT_CYCLES - 2)) begin
              r_data_oe <= 1'b1;
              r_state   <= REQ;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          REQ: begin
            // Release the clock; this cycle counts as the first of the timeout window
            r_clk_oe <= 1'b0;
            r_to     <= 19'd1;
            r_nfall  <= '0;
            r_state  <= BITS;
          end
          BITS: begin
            r_to <= w_to_next;
            if (w_clk_fall) begin
              if (r_nfall == 4'(PS2_FRAME_FALLS - 1)) begin
                r_data_oe <= 1'b0;
                r_state   <= ACK;
              end else begin
                r_data_oe <= ~r_shift[0];
                r_shift   <= {1'b0, r_shift[8:1]};
                r_nfall   <= r_nfall + 4'd1;
              end
            end
          end
          ACK: begin
            r_to <= w_to_next;
            if (w_clk_fall)
              r_state <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            r_to <= w_to_next;
            if (w_clk_level && w_data_level)
              r_state <= DONE;
          end
          DONE: begin
            r_done       <= 1'b1;
            r_rx_inhibit <= 1'b0;
            r_tx_ready   <= 1'b1;
            r_state      <= IDLE;
          end
          ERROR: begin
            r_clk_oe     <= 1'b0;
            r_data_oe    <= 1'b0;
            r_error      <= 1'b1;
            r_rx_inhibit <= 1'b0;
            r_tx_ready   <= 1'b1;
            r_state      <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready    = r_tx_ready;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign rx_inhibit  = r_rx_inhibit;
  assign done        = r_done;
  assign error       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain bus and a
// behavioural keyboard model. Honours PS2_TX_RETRY_EN.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 3000;
  localparam int TO   = 8000;
  localparam int FLT  = 8;
  localparam int HALF = 40;
`ifdef PS2_TX_RETRY_EN
  localparam int NTRY = 3;
`else
  localparam int NTRY = 1;
`endif

  logic       clk25 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       rx_inhibit;
  logic       done;
  logic       error;
  logic       dev_clk = 1'b0;   // 1 = device pulls clock low
  logic       dev_data = 1'b0;  // 1 = device pulls data low

  // Wired-AND open-drain bus with pull-ups
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk);
  assign ps2_data_in = ~(ps2_data_oe | dev_data);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FLT)
  ) dut (
    .clk25       (clk25),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_inhibit  (rx_inhibit),
    .done        (done),
    .error       (error)
  );

  always #20 clk25 = ~clk25;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation counters maintained on the falling edge
  int   cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   gap_cnt = 0;
  int   t_rise = 0;
  int   inh_len = 0;
  int   t_rel = 0;
  logic prev_clk_oe = 1'b0;

  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (error === 1'b1) err_cnt <= err_cnt + 1;
    if (tx_ready === 1'b0 && rx_inhibit === 1'b0) gap_cnt <= gap_cnt + 1;
    if (ps2_clk_oe === 1'b1 && prev_clk_oe === 1'b0) t_rise <= cyc;
    if (ps2_clk_oe === 1'b0 && prev_clk_oe === 1'b1) begin
      inh_len <= cyc - t_rise;
      t_rel   <= cyc;
    end
    prev_clk_oe <= ps2_clk_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference parity: 1 when the byte holds an even number of ones
  function automatic logic ref_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk25);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk25);
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, clocks 10 bits in, then the ACK clock
  task automatic dev_frame(input bit ack, input int abort_after,
                           output logic [7:0] got, output logic par,
                           output logic start_bit, output logic stop_bit, output bit ok);
    int n;
    got = 'x; par = 'x; start_bit = 'x; stop_bit = 'x; ok = 1'b0; n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 20000) begin
      @(negedge clk25);
      n++;
    end
    if (n >= 20000) return;
    repeat (10) @(negedge clk25);
    start_bit = ps2_data_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk25);
      dev_clk = 1'b0;
      repeat (HALF / 2) @(negedge clk25);
      if (k <= 8) got[k-1] = ps2_data_in;
      else if (k == 9) par = ps2_data_in;
      else stop_bit = ps2_data_in;
      if (k == abort_after) begin
        ok = 1'b1;
        return;
      end
      repeat (HALF / 2) @(negedge clk25);
    end
    dev_data = ack;
    repeat (20) @(negedge clk25);
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk25);
    dev_clk = 1'b0;
    repeat (HALF / 2) @(negedge clk25);
    dev_data = 1'b0;
    repeat (HALF / 2) @(negedge clk25);
    ok = 1'b1;
  endtask

  initial begin
    logic [7:0] got;
    logic       par, sb, pb, pre;
    bit         ok;
    logic [7:0] b;
    int         d0, e0, n;

    // Reset state
    repeat (4) @(posedge clk25);
    @(negedge clk25);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_rx_inhibit", rx_inhibit, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk25);

    // 1: 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hED);
    @(negedge clk25);
    check("t1_ready_drop", tx_ready, 0);
    check("t1_rx_inhibit", rx_inhibit, 1);
    dev_frame(1'b1, 0, got, par, sb, pb, ok);
    repeat (200) @(negedge clk25);
    $display("txn t1 byte=ED got=%0h par=%0b stop=%0b inhibit_len=%0d", got, par, pb, inh_len);
    check("t1_rts", ok, 1);
    check("t1_inhibit_len", inh_len, INH);
    check("t1_start", sb, 0);
    check("t1_byte", got, 8'hED);
    check("t1_parity", par, ref_parity(8'hED));
    check("t1_stop", pb, 1);
    check("t1_done", done_cnt - d0, 1);
    check("t1_error", err_cnt - e0, 0);
    check("t1_ready", tx_ready, 1);

    // 2: 0xF4, device NACKs every attempt
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4);
    for (int t = 0; t < NTRY; t++) begin
      dev_frame(1'b0, 0, got, par, sb, pb, ok);
      $display("txn t2 try=%0d got=%0h par=%0b", t, got, par);
      check("t2_rts", ok, 1);
      check("t2_byte", got, 8'hF4);
      check("t2_parity", par, ref_parity(8'hF4));
    end
    repeat (200) @(negedge clk25);
    check("t2_error", err_cnt - e0, 1);
    check("t2_done", done_cnt - d0, 0);
    check("t2_ready", tx_ready, 1);
    check("t2_clk_oe", ps2_clk_oe, 0);
    check("t2_data_oe", ps2_data_oe, 0);

    // 3: device never clocks -> timeout
    d0 = done_cnt; e0 = err_cnt;
    b = 8'($urandom_range(0, 255));
    send_byte(b);
    n = 0;
    while (error !== 1'b1 && n < NTRY * (INH + TO) + 2000) begin
      @(negedge clk25);
      n++;
    end
    $display("txn t3 byte=%0h wait=%0d timeout_after_req=%0d", b, n, cyc - t_rel);
    check("t3_error_seen", error, 1);
    check("t3_timeout_len", cyc - t_rel, TO);
    check("t3_clk_oe", ps2_clk_oe, 0);
    check("t3_data_oe", ps2_data_oe, 0);
    repeat (50) @(negedge clk25);
    check("t3_done", done_cnt - d0, 0);

    // 4: request while busy is ignored
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFF);
    repeat (100) @(negedge clk25);
    tx_data = 8'h00; tx_valid = 1'b1;
    repeat (500) @(negedge clk25);
    tx_valid = 1'b0;
    dev_frame(1'b1, 0, got, par, sb, pb, ok);
    repeat (300) @(negedge clk25);
    $display("txn t4 byte=FF got=%0h par=%0b", got, par);
    check("t4_byte", got, 8'hFF);
    check("t4_parity", par, ref_parity(8'hFF));
    check("t4_done", done_cnt - d0, 1);
    check("t4_no_new_frame", ps2_clk_oe, 0);
    check("t4_ready", tx_ready, 1);

    // 5: reset after the 4th fall (bit 3 of 0xF0 is 0, so data is driven)
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF0);
    dev_frame(1'b1, 4, got, par, sb, pb, ok);
    pre = ps2_data_oe;
    rst = 1'b1;
    @(negedge clk25);
    $display("txn t5 data_oe_before_rst=%0b after clk_oe=%0b data_oe=%0b", pre, ps2_clk_oe, ps2_data_oe);
    check("t5_bit3_drive", pre, 1);
    check("t5_clk_oe", ps2_clk_oe, 0);
    check("t5_data_oe", ps2_data_oe, 0);
    check("t5_ready", tx_ready, 1);
    check("t5_rx_inhibit", rx_inhibit, 0);
    rst = 1'b0;
    repeat (300) @(negedge clk25);
    check("t5_done", done_cnt - d0, 0);
    check("t5_error", err_cnt - e0, 0);

    // Random bytes with ACK
    for (int r = 0; r < 3; r++) begin
      d0 = done_cnt;
      b = 8'($urandom_range(0, 255));
      send_byte(b);
      dev_frame(1'b1, 0, got, par, sb, pb, ok);
      repeat (200) @(negedge clk25);
      $display("txn rnd%0d byte=%0h got=%0h par=%0b", r, b, got, par);
      check("rnd_byte", got, b);
      check("rnd_parity", par, ref_parity(b));
      check("rnd_stop", pb, 1);
      check("rnd_done", done_cnt - d0, 1);
    end

`ifdef PS2_TX_RETRY_EN
    // 6: two NACKs then ACK
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hED);
    for (int t = 0; t < 3; t++) begin
      dev_frame(t == 2, 0, got, par, sb, pb, ok);
      $display("txn t6 try=%0d got=%0h", t, got);
      check("t6_byte", got, 8'hED);
    end
    repeat (200) @(negedge clk25);
    check("t6_done", done_cnt - d0, 1);
    check("t6_error", err_cnt - e0, 0);
`endif

    check("rx_inhibit_gaps", gap_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
